// File: rtl/spu_sm_ctrl.sv
// Softmax row sequencer: max search, EXPU exp+sum, divider handshake and
// output streaming over one row buffer port. One row per start.
//   core_clk/rst_n     clock, async active-low reset
//   start/row_len      row request; busy/done/sm_state report progress
//   rd_*/wr_*          shared row buffer port (read data one cycle late)
//   din_q/exp_q        EXPU operand and result
//   div_*              reciprocal request/response with shared divider
//   out_*              normalised output stream, out_last on final element
module spu_sm_ctrl #(
  parameter int LEN_W    = 8,
  parameter int EXPU_LAT = 3,
  parameter int SUM_W    = 16,
  parameter int RECIP_W  = 16
) (
  input  logic               core_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   row_len,
  output logic               busy,
  output logic               done,
  output logic [2:0]         sm_state,
  output logic               rd_en,
  output logic [LEN_W-1:0]   rd_addr,
  input  logic [7:0]         rd_data,
  output logic               wr_en,
  output logic [LEN_W-1:0]   wr_addr,
  output logic [7:0]         wr_data,
  output logic [8:0]         din_q,
  input  logic [7:0]         exp_q,
  output logic               div_start,
  output logic [SUM_W-1:0]   div_sum,
  input  logic               div_done,
  input  logic [RECIP_W-1:0] div_recip,
  output logic               out_valid,
  output logic [7:0]         out_exp,
  output logic [RECIP_W-1:0] out_recip,
  output logic               out_last
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_EU_A = 3'b001,
    S_RECI = 3'b011,
    S_EU_B = 3'b100,
    S_MAX  = 3'b101
  } state_e;

  state_e state_q, state_nxt;

  logic [LEN_W-1:0]   n_q;
  logic [LEN_W-1:0]   rd_addr_q;
  logic [LEN_W-1:0]   wr_cnt_q;
  logic               rd_en_q;
  logic               rv_q;
  logic               rv_last_q;
  logic               done_q;
  logic               div_start_q;
  logic signed [7:0]  max_q;
  logic [8:0]         din_r;
  logic [SUM_W-1:0]   sum_q;
  logic [RECIP_W-1:0] recip_q;
  logic [EXPU_LAT-1:0] tag_q;

  logic               rd_last;
  logic               rd_start;
  logic               tag_exit;
  logic               exit_last;
  logic [SUM_W:0]     sum_ext;
  logic [SUM_W-1:0]   sum_sat;

  assign rd_last   = rd_en_q && (rd_addr_q == n_q - LEN_W'(1));
  assign tag_exit  = (state_q == S_EU_A) && tag_q[EXPU_LAT-1];
  assign exit_last = tag_exit && (wr_cnt_q == n_q - LEN_W'(1));
  assign sum_ext   = {1'b0, sum_q} + (SUM_W+1)'(exp_q);
  assign sum_sat   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    rd_start  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start && row_len != '0) state_nxt = S_MAX;
      S_MAX:  if (rv_last_q) state_nxt = S_EU_A;
      S_EU_A: if (exit_last) state_nxt = S_RECI;
      S_RECI: if (div_done) state_nxt = S_EU_B;
      S_EU_B: if (rv_last_q) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // every read pass restarts at address 0 on entry
    if (state_nxt != state_q &&
        (state_nxt == S_MAX || state_nxt == S_EU_A ||
         state_nxt == S_EU_B))
      rd_start = 1'b1;
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= '0;
      rd_addr_q   <= '0;
      wr_cnt_q    <= '0;
      rd_en_q     <= 1'b0;
      rv_q        <= 1'b0;
      rv_last_q   <= 1'b0;
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
      max_q       <= -8'sd128;
      din_r       <= '0;
      sum_q       <= '0;
      recip_q     <= '0;
      tag_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
      rv_q        <= rd_en_q;
      rv_last_q   <= rd_last;
      if (rd_start) begin
        rd_en_q   <= 1'b1;
        rd_addr_q <= '0;
      end else if (rd_en_q) begin
        if (rd_last) rd_en_q <= 1'b0;
        else         rd_addr_q <= rd_addr_q + LEN_W'(1);
      end
      if (state_q == S_IDLE && start) begin
        if (row_len == '0) begin
          done_q <= 1'b1;
        end else begin
          n_q      <= row_len;
          max_q    <= -8'sd128;
          sum_q    <= '0;
          wr_cnt_q <= '0;
        end
      end
      if (state_q == S_MAX && rv_q && $signed(rd_data) > max_q)
        max_q <= $signed(rd_data);
      if (state_q == S_EU_A) begin
        // tag marks which EXPU pipeline slots hold this row's data
        tag_q <= (tag_q << 1) | EXPU_LAT'(rv_q);
        if (rv_q)
          din_r <= {rd_data[7], rd_data} - {max_q[7], max_q};
      end
      if (tag_exit) begin
        sum_q    <= sum_sat;
        wr_cnt_q <= wr_cnt_q + LEN_W'(1);
      end
      if (exit_last) div_start_q <= 1'b1;
      if (state_q == S_RECI && div_done) recip_q <= div_recip;
      if (state_q == S_EU_B && rv_last_q) done_q <= 1'b1;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign sm_state  = state_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = tag_exit;
  assign wr_addr   = wr_cnt_q;
  assign wr_data   = tag_exit ? exp_q : '0;
  assign din_q     = din_r;
  assign div_start = div_start_q;
  assign div_sum   = sum_q;
  assign out_valid = (state_q == S_EU_B) && rv_q;
  assign out_exp   = out_valid ? rd_data : '0;
  assign out_recip = recip_q;
  assign out_last  = out_valid && rv_last_q;

endmodule

// File: tb/tb_spu_sm_ctrl.sv
// Bench for spu_sm_ctrl: buffer, EXPU and divider models around the DUT,
// row-level reference computed from scores, directed and random rows.
module tb_spu_sm_ctrl;
  localparam int LW  = 8;
  localparam int LAT = 3;
  localparam int SW  = 16;
  localparam int RW  = 16;

  logic          core_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] row_len = '0;
  logic          busy, done, rd_en, wr_en, div_start;
  logic          out_valid, out_last;
  logic [2:0]    sm_state;
  logic [LW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data, wr_data, exp_q, out_exp;
  logic [8:0]    din_q;
  logic [SW-1:0] div_sum;
  logic          div_done = 1'b0;
  logic [RW-1:0] div_recip = '0;
  logic [RW-1:0] out_recip;

  spu_sm_ctrl #(.LEN_W(LW), .EXPU_LAT(LAT), .SUM_W(SW), .RECIP_W(RW)) dut (
    .core_clk(core_clk), .rst_n(rst_n), .start(start),
    .row_len(row_len), .busy(busy), .done(done),
    .sm_state(sm_state), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .din_q(din_q), .exp_q(exp_q),
    .div_start(div_start), .div_sum(div_sum), .div_done(div_done),
    .div_recip(div_recip), .out_valid(out_valid), .out_exp(out_exp),
    .out_recip(out_recip), .out_last(out_last)
  );

  always #5 core_clk = ~core_clk;

  logic all_nz;
  assign all_nz = busy | done | (|sm_state) | rd_en | (|rd_addr) |
                  wr_en | (|wr_addr) | (|wr_data) | (|din_q) |
                  div_start | (|div_sum) | out_valid | (|out_exp) |
                  (|out_recip) | out_last;

  // row buffer
  int         sc [256];
  logic [7:0] mem [256];
  logic       load_go = 1'b0;
  always @(posedge core_clk) begin
    if (load_go)
      for (int k = 0; k < 256; k++) mem[k] = 8'(sc[k]);
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] = wr_data;
  end

  // EXPU: exp = 255 + din, visible LAT-1 cycles after din_q, holds outside EU_STAGE_A
  logic signed [8:0] ep [LAT-1];
  logic signed [9:0] ex_full;
  always @(posedge core_clk)
    if (sm_state == 3'b001) begin
      ep[0] <= din_q;
      for (int i = 1; i < LAT - 1; i++) ep[i] <= ep[i-1];
    end
  assign ex_full = 10'sd255 + ep[LAT-2];
  assign exp_q   = ex_full[7:0];

  // divider
  int            div_delay = 0;
  logic [RW-1:0] recip_val = '0;
  int            stale_req = 0;
  int            stale_ack = 0;
  always begin
    @(negedge core_clk);
    if (stale_req != stale_ack) begin
      stale_ack = stale_req;
      div_recip = 16'hdead;
      div_done  = 1'b1;
      @(negedge core_clk);
      div_done  = 1'b0;
    end else if (div_start) begin
      repeat (div_delay) @(negedge core_clk);
      div_recip = recip_val;
      div_done  = 1'b1;
      @(negedge core_clk);
      div_done  = 1'b0;
    end
  end

  // monitor
  int            clr_req = 0;
  int            clr_ack = 0;
  logic [LW-1:0] w_addr [$];
  logic [7:0]    w_data [$];
  int            w_din [$];
  logic [7:0]    o_exp [$];
  logic [RW-1:0] o_rec [$];
  bit            o_last [$];
  int            done_cnt, rd_cnt, ds_cnt, eua_cyc, reci_cyc, dsum_chg, coll;
  logic [SW-1:0] dsum0;
  always @(negedge core_clk) begin
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      w_addr.delete(); w_data.delete(); w_din.delete();
      o_exp.delete(); o_rec.delete(); o_last.delete();
      done_cnt = 0; rd_cnt = 0; ds_cnt = 0; eua_cyc = 0;
      reci_cyc = 0; dsum_chg = 0; coll = 0; dsum0 = '0;
    end
    if (wr_en) begin
      w_addr.push_back(wr_addr);
      w_data.push_back(wr_data);
      w_din.push_back(int'(ep[LAT-2]));
    end
    if (wr_en && rd_en && wr_addr == rd_addr) coll++;
    if (out_valid) begin
      o_exp.push_back(out_exp);
      o_rec.push_back(out_recip);
      o_last.push_back(out_last);
    end
    if (done) done_cnt++;
    if (rd_en) rd_cnt++;
    if (div_start) ds_cnt++;
    if (sm_state == 3'b001) eua_cyc++;
    if (sm_state == 3'b011) begin
      reci_cyc++;
      if (reci_cyc == 1) dsum0 = div_sum;
      else if (div_sum != dsum0) dsum_chg++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_row();
    @(posedge core_clk); #1 load_go = 1'b1;
    @(posedge core_clk); #1 load_go = 1'b0;
  endtask

  task automatic clear_mon();
    clr_req++;
    @(negedge core_clk);
  endtask

  task automatic run_row(input int n, input int dly,
                         input logic [RW-1:0] rv, input bit mid);
    int mx, s, cyc, gap;
    int ex [$];
    bit seen;
    mx = -128;
    for (int k = 0; k < n; k++) if (sc[k] > mx) mx = sc[k];
    s = 0;
    for (int k = 0; k < n; k++) begin
      ex.push_back(255 + sc[k] - mx);
      s += 255 + sc[k] - mx;
    end
    if (s > 65535) s = 65535;
    div_delay = dly;
    recip_val = rv;
    load_row();
    clear_mon();
    @(posedge core_clk); #1 start = 1'b1; row_len = LW'(n);
    @(posedge core_clk); #1 start = 1'b0;
    seen = 1'b0; cyc = 0; gap = 0;
    while (!seen && cyc < 3000) begin
      @(negedge core_clk);
      cyc++;
      if (mid && cyc == 4) start = 1'b1;
      if (mid && cyc == 5) start = 1'b0;
      if (done) seen = 1'b1;
      else if (!busy) gap++;
    end
    start = 1'b0;
    chk("row_done_seen", int'(seen), 1);
    repeat (3) @(negedge core_clk);
    chk("done_once", done_cnt, 1);
    chk("busy_held", gap, 0);
    chk("busy_end", int'(busy), 0);
    chk("state_end", int'(sm_state), 0);
    chk("rd_count", rd_cnt, 3 * n);
    chk("div_start_once", ds_cnt, 1);
    chk("div_sum", int'(dsum0), s);
    chk("div_sum_stable", dsum_chg, 0);
    chk("reci_cycles", reci_cyc, dly + 1);
    chk("eua_cycles", eua_cyc, n + 1 + LAT);
    chk("rw_collision", coll, 0);
    chk("wr_count", w_addr.size(), n);
    for (int k = 0; k < n && k < w_addr.size(); k++) begin
      chk($sformatf("wr_addr[%0d]", k), int'(w_addr[k]), k);
      chk($sformatf("wr_data[%0d]", k), int'(w_data[k]), ex[k]);
      chk($sformatf("din_q[%0d]", k), w_din[k], sc[k] - mx);
    end
    chk("out_count", o_exp.size(), n);
    for (int k = 0; k < n && k < o_exp.size(); k++) begin
      chk($sformatf("out_exp[%0d]", k), int'(o_exp[k]), ex[k]);
      chk($sformatf("out_recip[%0d]", k), int'(o_rec[k]), int'(rv));
      chk($sformatf("out_last[%0d]", k), int'(o_last[k]),
          int'(k == n - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, n;
    repeat (3) @(posedge core_clk);
    #1;
    chk("rst_outputs_zero", int'(all_nz), 0);
    chk("rst_state", int'(sm_state), 0);
    @(negedge core_clk) rst_n = 1'b1;

    sc[0] = 10; sc[1] = -5; sc[2] = 10; sc[3] = 0;
    run_row(4, 3, 16'h1234, 1'b0);

    clear_mon();
    @(posedge core_clk); #1 start = 1'b1; row_len = '0;
    @(posedge core_clk); #1 start = 1'b0;
    @(negedge core_clk);
    chk("len0_done", int'(done), 1);
    chk("len0_busy", int'(busy), 0);
    chk("len0_state", int'(sm_state), 0);
    @(negedge core_clk);
    chk("len0_done_drop", int'(done), 0);
    repeat (3) @(negedge core_clk);
    chk("len0_rd_count", rd_cnt, 0);
    chk("len0_done_once", done_cnt, 1);

    sc[0] = -128;
    run_row(1, 0, 16'h00f1, 1'b0);

    sc[0] = -128; sc[1] = 127;
    run_row(2, 1, 16'h7777, 1'b0);

    for (int k = 0; k < 4; k++) sc[k] = int'($urandom_range(0, 255)) - 128;
    run_row(4, 20, 16'h0beef, 1'b0);

    for (int k = 0; k < 6; k++) sc[k] = int'($urandom_range(0, 255)) - 128;
    run_row(6, 2, 16'h4321, 1'b1);

    sc[0] = 5; sc[1] = -3; sc[2] = 7; sc[3] = 1; sc[4] = 2;
    load_row();
    clear_mon();
    @(posedge core_clk); #1 start = 1'b1; row_len = LW'(5);
    @(posedge core_clk); #1 start = 1'b0;
    cyc = 0;
    while (sm_state != 3'b001 && cyc < 200) begin
      @(negedge core_clk);
      cyc++;
    end
    chk("abort_reach_eua", int'(sm_state), 1);
    repeat (2) @(negedge core_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", int'(all_nz), 0);
    chk("abort_state", int'(sm_state), 0);
    repeat (2) @(negedge core_clk);
    rst_n = 1'b1;
    stale_req++;
    repeat (4) @(negedge core_clk);
    chk("stale_state", int'(sm_state), 0);
    chk("stale_recip", int'(out_recip), 0);
    chk("stale_busy", int'(busy), 0);
    sc[0] = -20; sc[1] = 33; sc[2] = 4;
    run_row(3, 2, 16'h0abc, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 24));
      for (int k = 0; k < n; k++)
        sc[k] = int'($urandom_range(0, 255)) - 128;
      run_row(n, int'($urandom_range(0, 6)), 16'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spu_sm_ctrl.md
Name: spu_sm_ctrl

Overview:
Softmax row sequencer for the SPU softmax path. It owns `sm_state` and drives the PWL exponent unit (EXPU), sharing one row buffer port between four passes: max search, exponent plus sum, reciprocal handshake with the shared divider, and normalised output streaming. One row of int8 scores is processed per `start`.

Parameters:
LEN_W, 8, width of row length and buffer address (max row 2^LEN_W-1 elements)
EXPU_LAT, 3, cycles from `din_q` presented (sampled in EU_STAGE_A) to `exp_q` valid
SUM_W, 16, exp-sum accumulator width; must be at least LEN_W+8
RECIP_W, 16, divider result width

Ports:
core_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a row; ignored while busy
row_len  in  LEN_W  element count, sampled at start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at row end
sm_state  out  3  IDLE=000, EU_STAGE_A=001, RECI=011, EU_STAGE_B=100, MAX=101
rd_en  out  1  buffer read strobe
rd_addr  out  LEN_W  buffer read address
rd_data  in  8  signed score or stored exp; valid the cycle after rd_en
wr_en  out  1  buffer write strobe (exp results)
wr_addr  out  LEN_W  write address
wr_data  out  8  exp value written back
din_q  out  9  signed x-max to EXPU
exp_q  in  8  unsigned EXPU result
div_start  out  1  one-cycle divider request
div_sum  out  SUM_W  dividend-side sum, held stable while in RECI
div_done  in  1  divider completion pulse
div_recip  in  RECIP_W  reciprocal, valid with div_done
out_valid  out  1  output element valid (no backpressure)
out_exp  out  8  exp value
out_recip  out  RECIP_W  latched reciprocal
out_last  out  1  with last out_valid of row

Behaviour:
- Reset values: all outputs 0, `sm_state`=IDLE, internal max=-128, sum=0, counters=0.
- IDLE -> MAX on start when `row_len`>0. When `row_len`=0: no state change; `done` pulses the next cycle; `busy` stays 0.
- MAX: issue rd_addr 0..N-1 on consecutive cycles with rd_en=1. Each returned rd_data updates max as a signed compare. Move to EU_STAGE_A the cycle after the last datum returns.
- EU_STAGE_A: re-read addresses 0..N-1. The data returned for address k is registered as din_q = sign-extended(x) - sign-extended(max). The range is -255..0, so no saturation is needed.
- A valid tag shift register of depth EXPU_LAT tracks din_q.
- When a tag exits, exp_q for element k is:
  - written to address k (wr_en, wr_addr=k, wr_data=exp_q);
  - added zero-extended into sum. The sum saturates at 2^SUM_W-1.
- Tags for pipeline contents left over from a prior row are 0, so those results are ignored.
- `sm_state` stays EU_STAGE_A until the last tag exits (drain); EXPU holds its registers only in this state. Then go to RECI.
- RECI: pulse div_start in the first RECI cycle; div_sum=sum, held stable. Wait any number of cycles for div_done, then latch div_recip to out_recip and go to EU_STAGE_B. A div_done arriving in the same cycle as div_start is accepted.
- EU_STAGE_B: read addresses 0..N-1. One cycle after each rd_en, assert out_valid with out_exp=rd_data. out_last accompanies element N-1.
- After the final output: go to IDLE, pulse done, drop busy in that same cycle.
- The buffer is never read and written at the same address in the same cycle. In EU_STAGE_A the write of element k always trails its read, so this holds.
- Asserting rst_n mid-row aborts immediately to the reset values. A stale div_done arriving afterwards in IDLE is ignored.
- start during busy is ignored and does not queue.

Test Plan:
- Row N=4, scores {10,-5,10,0}; EXPU model exp_q=max(0,255+din_q) -> max=10. din_q sequence {0,-15,0,-10}. Writes {255,240,255,245}; div_sum=995. With div_recip=0x1234: outputs 255,240,255,245 each with out_recip=0x1234, out_last on the fourth, done once.
- row_len=0 -> done pulse one cycle after start; sm_state stays IDLE; no rd_en.
- N=1, score -128 -> din_q=0, sum=exp_q(0). Check EU_STAGE_A lasts exactly 1+1+EXPU_LAT cycles.
- Scores {-128,127} -> din_q {-255,0}, confirming 9-bit range with no wrap.
- Divider delayed 20 cycles -> sm_state holds RECI; div_sum is stable throughout; div_start pulses exactly once.
- rst_n pulled low in EU_STAGE_A -> all outputs 0 asynchronously. A new start then completes a fresh N=3 row correctly, and the stale div_done is ignored.
- start asserted mid-row -> no effect; busy stays high and done pulses exactly once.
